// File: rtl/reg_writeback_queue.sv
// reg_writeback_queue: FIFO of {dest register, data} results draining one
// entry per cycle onto the register file write port, with per-read-port
// hazard detection against every write still in flight.
// Optional newest-match forwarding is built when REG_WB_FWD_EN is defined;
// without it the forward outputs are tied to zero.

module reg_writeback_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 5,
  parameter int unsigned DW    = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [AW-1:0]            in_addr,
  input  logic [DW-1:0]            in_data,
  input  logic                     drain_en,
  output logic                     RegWrite,
  output logic [AW-1:0]            wrAddr,
  output logic [DW-1:0]            wrData,
  input  logic [AW-1:0]            rdAddrA,
  input  logic [AW-1:0]            rdAddrB,
  output logic                     hazA,
  output logic                     hazB,
  output logic                     fwdValidA,
  output logic [DW-1:0]            fwdDataA,
  output logic                     fwdValidB,
  output logic [DW-1:0]            fwdDataB,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned LW = PW + 1;

  // Entry storage; validity comes from count/rd_ptr only.
  logic [AW-1:0] ent_addr_q [DEPTH];
  logic [DW-1:0] ent_data_q [DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] count_q,  count_d;

  logic          regwrite_q, regwrite_d;
  logic [AW-1:0] wraddr_q,   wraddr_d;
  logic [DW-1:0] wrdata_q,   wrdata_d;

  logic             push;
  logic             pop;
  logic [DEPTH-1:0] ent_valid;

  // Slot holding the entry 'age' positions after the head.
  function automatic logic [PW-1:0] slot_at(input logic [PW-1:0] base,
                                            input int unsigned   age);
    return PW'(base + PW'(age));
  endfunction

  // Acceptance depends on occupancy only.
  assign in_ready = (count_q < LW'(DEPTH));
  assign push     = in_valid & in_ready;
  assign pop      = (count_q != '0) & drain_en;

  assign RegWrite = regwrite_q;
  assign wrAddr   = wraddr_q;
  assign wrData   = wrdata_q;
  assign level    = count_q;

  // Next-state for pointers, occupancy and the write-port register.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    regwrite_d = 1'b0;
    wraddr_d   = wraddr_q;
    wrdata_d   = wrdata_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end

    if (pop) begin
      rd_ptr_d   = rd_ptr_q + PW'(1);
      regwrite_d = 1'b1;
      wraddr_d   = ent_addr_q[rd_ptr_q];
      wrdata_d   = ent_data_q[rd_ptr_q];
    end

    unique case ({push, pop})
      2'b10:   count_d = count_q + LW'(1);
      2'b01:   count_d = count_q - LW'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state and write port; reset drops any pending write at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      regwrite_q <= 1'b0;
      wraddr_q   <= '0;
      wrdata_q   <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      regwrite_q <= regwrite_d;
      wraddr_q   <= wraddr_d;
      wrdata_q   <= wrdata_d;
    end
  end

  // Entry storage write; no reset needed since count qualifies entries.
  always_ff @(posedge clk) begin
    if (push) begin
      ent_addr_q[wr_ptr_q] <= in_addr;
      ent_data_q[wr_ptr_q] <= in_data;
    end
  end

  // Per-slot validity: slot is live if its age from the head is below count.
  always_comb begin
    ent_valid = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      ent_valid[i] = (LW'(PW'(PW'(i) - rd_ptr_q)) < count_q);
    end
  end

  // Port A hazard: any live entry or the in-flight write targets rdAddrA.
  always_comb begin
    hazA = regwrite_q && (wraddr_q == rdAddrA);
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (ent_valid[i] && (ent_addr_q[i] == rdAddrA)) begin
        hazA = 1'b1;
      end
    end
  end

  // Port B hazard, same rule as port A.
  always_comb begin
    hazB = regwrite_q && (wraddr_q == rdAddrB);
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (ent_valid[i] && (ent_addr_q[i] == rdAddrB)) begin
        hazB = 1'b1;
      end
    end
  end

`ifdef REG_WB_FWD_EN
  assign fwdValidA = hazA;
  assign fwdValidB = hazB;

  // Port A forward: scan oldest to youngest so the newest match wins.
  always_comb begin
    fwdDataA = '0;
    if (regwrite_q && (wraddr_q == rdAddrA)) begin
      fwdDataA = wrdata_q;
    end
    for (int unsigned j = 0; j < DEPTH; j++) begin
      if (ent_valid[slot_at(rd_ptr_q, j)] &&
          (ent_addr_q[slot_at(rd_ptr_q, j)] == rdAddrA)) begin
        fwdDataA = ent_data_q[slot_at(rd_ptr_q, j)];
      end
    end
  end

  // Port B forward, same priority as port A.
  always_comb begin
    fwdDataB = '0;
    if (regwrite_q && (wraddr_q == rdAddrB)) begin
      fwdDataB = wrdata_q;
    end
    for (int unsigned j = 0; j < DEPTH; j++) begin
      if (ent_valid[slot_at(rd_ptr_q, j)] &&
          (ent_addr_q[slot_at(rd_ptr_q, j)] == rdAddrB)) begin
        fwdDataB = ent_data_q[slot_at(rd_ptr_q, j)];
      end
    end
  end
`else
  assign fwdValidA = 1'b0;
  assign fwdValidB = 1'b0;
  assign fwdDataA  = '0;
  assign fwdDataB  = '0;
`endif

endmodule

// File: tb/tb_reg_writeback_queue.sv
// Bench for reg_writeback_queue: directed scenarios plus random traffic,
// checked every cycle against a queue-based reference model.

module tb_reg_writeback_queue;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned AW    = 5;
  localparam int unsigned DW    = 32;

  logic          clk;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [AW-1:0] in_addr;
  logic [DW-1:0] in_data;
  logic          drain_en;
  logic          RegWrite;
  logic [AW-1:0] wrAddr;
  logic [DW-1:0] wrData;
  logic [AW-1:0] rdAddrA;
  logic [AW-1:0] rdAddrB;
  logic          hazA;
  logic          hazB;
  logic          fwdValidA;
  logic [DW-1:0] fwdDataA;
  logic          fwdValidB;
  logic [DW-1:0] fwdDataB;
  logic [2:0]    level;

  reg_writeback_queue #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_addr(in_addr), .in_data(in_data),
    .drain_en(drain_en),
    .RegWrite(RegWrite), .wrAddr(wrAddr), .wrData(wrData),
    .rdAddrA(rdAddrA), .rdAddrB(rdAddrB),
    .hazA(hazA), .hazB(hazB),
    .fwdValidA(fwdValidA), .fwdDataA(fwdDataA),
    .fwdValidB(fwdValidB), .fwdDataB(fwdDataB),
    .level(level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: pending entries in order, plus the write-port register.
  logic [AW-1:0] q_addr[$];
  logic [DW-1:0] q_data[$];
  logic          m_rw = 1'b0;
  logic [AW-1:0] m_wa = '0;
  logic [DW-1:0] m_wd = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic model_haz(input logic [AW-1:0] a);
    logic h;
    h = m_rw && (m_wa == a);
    foreach (q_addr[i]) if (q_addr[i] == a) h = 1'b1;
    return h;
  endfunction

  // Newest pending write to 'a': queue tail beats head beats write port.
  function automatic logic [DW-1:0] model_fwd(input logic [AW-1:0] a);
    logic [DW-1:0] v;
    v = '0;
    if (m_rw && (m_wa == a)) v = m_wd;
    foreach (q_addr[i]) if (q_addr[i] == a) v = q_data[i];
    return v;
  endfunction

  task automatic compare_all();
    logic          efa, efb;
    logic [DW-1:0] eda, edb;
`ifdef REG_WB_FWD_EN
    efa = model_haz(rdAddrA);
    efb = model_haz(rdAddrB);
    eda = model_fwd(rdAddrA);
    edb = model_fwd(rdAddrB);
`else
    efa = 1'b0;
    efb = 1'b0;
    eda = '0;
    edb = '0;
`endif
    check("level",    64'(level),    64'(q_addr.size()));
    check("in_ready", 64'(in_ready), 64'(q_addr.size() < DEPTH));
    check("RegWrite", 64'(RegWrite), 64'(m_rw));
    check("wrAddr",   64'(wrAddr),   64'(m_wa));
    check("wrData",   64'(wrData),   64'(m_wd));
    check("hazA",     64'(hazA),     64'(model_haz(rdAddrA)));
    check("hazB",     64'(hazB),     64'(model_haz(rdAddrB)));
    check("fwdValidA", 64'(fwdValidA), 64'(efa));
    check("fwdValidB", 64'(fwdValidB), 64'(efb));
    check("fwdDataA", 64'(fwdDataA), 64'(eda));
    check("fwdDataB", 64'(fwdDataB), 64'(edb));
  endtask

  // One clock: drive at negedge, check settled outputs, advance model at posedge.
  task automatic step(input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input logic dr, input logic [AW-1:0] ra, input logic [AW-1:0] rb);
    logic do_push, do_pop;
    @(negedge clk);
    in_valid = v;
    in_addr  = a;
    in_data  = d;
    drain_en = dr;
    rdAddrA  = ra;
    rdAddrB  = rb;
    #1;
    compare_all();
    @(posedge clk);
    do_push = v && (q_addr.size() < DEPTH);
    do_pop  = dr && (q_addr.size() > 0);
    if (do_pop) begin
      m_rw = 1'b1;
      m_wa = q_addr.pop_front();
      m_wd = q_data.pop_front();
    end else begin
      m_rw = 1'b0;
    end
    if (do_push) begin
      q_addr.push_back(a);
      q_data.push_back(d);
    end
  endtask

  initial begin
    reset    = 1'b0;
    in_valid = 1'b0;
    in_addr  = '0;
    in_data  = '0;
    drain_en = 1'b0;
    rdAddrA  = '0;
    rdAddrB  = '0;

    // Reset held for two cycles.
    #1;
    check("rst_RegWrite", 64'(RegWrite), 64'd0);
    check("rst_level",    64'(level),    64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // Idle after reset.
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd1);

    // Single push with drain enabled; write port shows it two cycles later.
    step(1'b1, 5'd5, 32'hDEADBEEF, 1'b1, 5'd5, 5'd6);
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 5'd6);
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 5'd6);
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 5'd6);

    // Fill with drain off, offer one beyond full, then drain in order.
    for (int i = 1; i <= 4; i++) step(1'b1, AW'(i), DW'(i), 1'b0, 5'd2, 5'd4);
    step(1'b1, 5'd6, 32'd6, 1'b0, 5'd6, 5'd1);
    check("full_level", 64'(level), 64'd4);
    for (int i = 0; i < 6; i++) step(1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 5'd6);

    // Two writes to r7: newest data forwards; hazard persists through retirement.
    step(1'b1, 5'd7, 32'd10, 1'b0, 5'd7, 5'd8);
    step(1'b1, 5'd7, 32'd20, 1'b0, 5'd7, 5'd8);
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd7, 5'd8);
    for (int i = 0; i < 4; i++) step(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 5'd8);

    // Register 0 behaves as any other register.
    step(1'b1, 5'd0, 32'h1234, 1'b1, 5'd0, 5'd0);
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 5'd1);
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 5'd1);

    // Mid-drain reset: pending write and queued entries vanish.
    for (int i = 0; i < 3; i++) step(1'b1, AW'(9 + i), DW'(100 + i), 1'b0, 5'd9, 5'd10);
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 5'd10);
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 5'd10);
    #2;
    in_valid = 1'b0;
    reset    = 1'b0;
    #1;
    check("rst_mid_RegWrite", 64'(RegWrite), 64'd0);
    check("rst_mid_level",    64'(level),    64'd0);
    check("rst_mid_wrAddr",   64'(wrAddr),   64'd0);
    q_addr.delete();
    q_data.delete();
    m_rw = 1'b0;
    m_wa = '0;
    m_wd = '0;
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) step(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 5'd11);

    // Random traffic over a small address range to provoke hazards.
    for (int i = 0; i < 3000; i++) begin
      step(1'($urandom_range(0, 9) < 6),
           AW'($urandom_range(0, 7)),
           DW'($urandom),
           1'($urandom_range(0, 9) < ((i / 500) % 2 == 0 ? 5 : 8)),
           AW'($urandom_range(0, 7)),
           AW'($urandom_range(0, 7)));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/reg_writeback_queue.md
Name: reg_writeback_queue

Overview:
- Write-side producer for the 32x32 register file. Buffers completed results as {destination register, data} pairs in a small FIFO.
- Drains at most one entry per cycle onto the register file write port (RegWrite/wrAddr/wrData).
- Reports per-read-port hazards for any read address with a write still in flight, so decode can stall.

Parameters:
DEPTH, 4, FIFO entries; power of two, >= 2
AW, 5, register address width
DW, 32, register data width

Ports:
clk  input  1  clock; all state updates on posedge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
in_valid  input  1  producer offers a result this cycle
in_ready  output  1  queue can accept; in_valid & in_ready = push at posedge
in_addr  input  AW  destination register of offered result
in_data  input  DW  result value
drain_en  input  1  1 = pop allowed this cycle; 0 = hold write port idle
RegWrite  output  1  register file write enable, registered
wrAddr  output  AW  register file write address, registered
wrData  output  DW  register file write data, registered
rdAddrA  input  AW  decode read address, port A
rdAddrB  input  AW  decode read address, port B
hazA  output  1  port A address has a pending write
hazB  output  1  port B address has a pending write
fwdValidA  output  1  port A forward data valid (FWD_EN only)
fwdDataA  output  DW  port A forward data
fwdValidB  output  1  port B forward data valid
fwdDataB  output  DW  port B forward data
level  output  $clog2(DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (reset=0, asynchronous):
  - count, rd_ptr and wr_ptr clear to 0.
  - RegWrite=0, wrAddr=0, wrData=0, level=0.
  - Entry storage is not cleared; entries are qualified by count only.
  - A reset asserted mid-operation discards all queued entries and any pending write. No partial write is issued.
- in_ready = (count < DEPTH). It is a pure function of state, with no combinational path from drain_en or in_valid.
- Push: at posedge when in_valid & in_ready, {in_addr, in_data} is stored at wr_ptr and wr_ptr increments.
- Pop: at posedge when count > 0 & drain_en, the head entry loads into wrAddr/wrData, RegWrite <= 1, and rd_ptr increments.
- Otherwise RegWrite <= 0 and wrAddr/wrData hold their last values.
- Pointer wrap-around: pointers are $clog2(DEPTH) bits and wrap naturally at DEPTH.
- Occupancy update per posedge:
  - push only: count +1
  - pop only: count -1
  - push and pop together: count unchanged; legal at any count in 1..DEPTH-1
  - at count = DEPTH, push is blocked even if a pop occurs in the same cycle
- Latency: an entry pushed at edge N is popped at edge N+1 at the earliest (queue otherwise empty, drain_en=1). RegWrite is high during cycle N+1..N+2, and the register file commits at edge N+2.
- Ordering: strictly FIFO. Writes to the same register retire in push order.
- Empty with drain_en=1: RegWrite <= 0. Full with in_valid=1: no push, no state change from the offer.
- drain_en=0: no pop. Pushes continue until full.
- Hazards (combinational): hazA=1 if any valid FIFO entry has addr==rdAddrA, OR (RegWrite=1 and wrAddr==rdAddrA). hazB is the same for rdAddrB.
- The current-cycle offer (in_valid) is not included in the hazard check.
- Register 0 is an ordinary writable register; no special case.
- level = count.

Optional Feature:
- Macro: REG_WB_FWD_EN.
- Defined:
  - fwdValidA = hazA.
  - fwdDataA = data of the newest match: FIFO entries from youngest (wr_ptr-1) to oldest, then the write-port register.
  - Port B is identical.
- Undefined: fwdValidA/B=0, fwdDataA/B=0 constant, and no comparator priority logic is synthesized. hazA/hazB are unaffected.

Test Plan:
- Reset low for 2 cycles, release, hold in_valid=0 -> RegWrite=0, wrAddr=0, wrData=0, level=0, in_ready=1.
- Push {r5, 32'hDEADBEEF} at edge 1, drain_en=1 -> RegWrite=1, wrAddr=5, wrData=DEADBEEF during cycle after edge 2 only; level back to 0.
- drain_en=0, push r1..r4 (data 1..4), then offer r6 -> in_ready=0 after the 4th push, level=4, r6 not accepted.
  - Then drain_en=1 -> writes r1,r2,r3,r4 on 4 consecutive cycles in order; in_ready=1 after the first pop.
- drain_en=0, push {r7,10} then {r7,20}, rdAddrA=7, rdAddrB=8 -> hazA=1, hazB=0.
  - With REG_WB_FWD_EN: fwdDataA=20.
  - Drain both -> hazA stays 1 through the cycle RegWrite presents r7=20, then drops to 0.
- Fill 3 entries, assert reset for 1 cycle mid-drain -> RegWrite drops to 0 immediately (async), level=0, and no further writes issue after release.
